// File: rtl/axil_sig_dumper.sv
// Compliance-run signature dumper: waits for CPU halt or a cycle timeout, then reads the
// signature window over an AXI-Lite master read port and streams each word out.
module axil_sig_dumper #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_sig_begin,
    input  logic [ADDR_WIDTH-1:0] cfg_sig_end,
    input  logic [CNT_WIDTH-1:0]  cfg_timeout,
    input  logic                  halt,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,
    output logic [DATA_WIDTH-1:0] sig_tdata,
    output logic                  sig_tvalid,
    input  logic                  sig_tready,
    output logic                  sig_tlast,
    output logic                  busy,
    output logic                  done,
    output logic                  timed_out,
    output logic                  resp_err,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    localparam int unsigned STEP = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] STEP_A     = ADDR_WIDTH'(STEP);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STEP - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);

    typedef enum logic [2:0] {StIdle, StRun, StAr, StR, StOut, StDone} state_e;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [ADDR_WIDTH-1:0] r_end;
    logic [CNT_WIDTH-1:0]  r_timeout;
    logic [CNT_WIDTH-1:0]  r_cycle_count;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_timed_out;
    logic                  r_resp_err;

    logic                  w_start_ok;
    logic                  w_timeout_hit;
    logic                  w_empty;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;

    assign w_start_ok    = start && ((r_state == StIdle) || (r_state == StDone));
    assign w_timeout_hit = (r_timeout != '0) && (r_cycle_count == r_timeout);
    assign w_addr_nxt    = r_cur_addr + STEP_A;
    // Only true on the first AR entry when the window is empty; later entries have cur < end.
    assign w_empty       = (r_cur_addr >= r_end);
    assign w_last        = (w_addr_nxt >= r_end);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle, StDone: if (start) w_state_nxt = StRun;
            StRun:          if (halt || w_timeout_hit) w_state_nxt = StAr;
            StAr: begin
                if (w_empty) begin
                    w_state_nxt = StDone;
                end else if (m_axil_arready) begin
                    w_state_nxt = StR;
                end
            end
            StR:            if (m_axil_rvalid) w_state_nxt = StOut;
            StOut:          if (sig_tready) w_state_nxt = w_last ? StDone : StAr;
            default:        w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        sig_tvalid     = 1'b0;
        sig_tlast      = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        unique case (r_state)
            StRun: busy = 1'b1;
            StAr: begin
                busy           = 1'b1;
                m_axil_arvalid = !w_empty;
            end
            StR: begin
                busy          = 1'b1;
                m_axil_rready = 1'b1;
            end
            StOut: begin
                busy       = 1'b1;
                sig_tvalid = 1'b1;
                sig_tlast  = w_last;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cur_addr    <= '0;
            r_end         <= '0;
            r_timeout     <= '0;
            r_cycle_count <= '0;
            r_data        <= '0;
            r_timed_out   <= 1'b0;
            r_resp_err    <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_cur_addr    <= cfg_sig_begin & ALIGN_MASK;
                r_end         <= cfg_sig_end & ALIGN_MASK;
                r_timeout     <= cfg_timeout;
                r_cycle_count <= '0;
                r_timed_out   <= 1'b0;
                r_resp_err    <= 1'b0;
            end
            // Halt wins a tie with the timeout; the count freezes when the wait ends.
            if ((r_state == StRun) && !halt) begin
                if (w_timeout_hit) begin
                    r_timed_out <= 1'b1;
                end else if (!(&r_cycle_count)) begin
                    r_cycle_count <= r_cycle_count + CNT_ONE;
                end
            end
            if ((r_state == StR) && m_axil_rvalid) begin
                r_data <= m_axil_rdata;
                if (m_axil_rresp != 2'b00) r_resp_err <= 1'b1;
            end
            if ((r_state == StOut) && sig_tready) begin
                r_cur_addr <= w_addr_nxt;
            end
        end
    end

    assign m_axil_araddr = r_cur_addr;
    assign m_axil_arprot = 3'b000;
    assign sig_tdata     = r_data;
    assign timed_out     = r_timed_out;
    assign resp_err      = r_resp_err;
    assign cycle_count   = r_cycle_count;

endmodule

// File: tb/tb_axil_sig_dumper.sv
// Directed bench for axil_sig_dumper: a zero-wait AXI-Lite slave returns {16'hC0DE, addr[15:0]}
// and a monitor records AR addresses and stream beats for per-scenario comparison.
module tb_axil_sig_dumper;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        start;
    logic [31:0] cfg_sig_begin;
    logic [31:0] cfg_sig_end;
    logic [31:0] cfg_timeout;
    logic        halt;
    logic [31:0] m_axil_araddr;
    logic [2:0]  m_axil_arprot;
    logic        m_axil_arvalid;
    logic        m_axil_arready;
    logic [31:0] m_axil_rdata;
    logic [1:0]  m_axil_rresp;
    logic        m_axil_rvalid;
    logic        m_axil_rready;
    logic [31:0] sig_tdata;
    logic        sig_tvalid;
    logic        sig_tready;
    logic        sig_tlast;
    logic        busy;
    logic        done;
    logic        timed_out;
    logic        resp_err;
    logic [31:0] cycle_count;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] err_addr;
    logic [31:0] ar_q[$];
    logic [31:0] bd_q[$];
    logic        bl_q[$];

    axil_sig_dumper #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .CNT_WIDTH (32)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .cfg_sig_begin (cfg_sig_begin),
        .cfg_sig_end   (cfg_sig_end),
        .cfg_timeout   (cfg_timeout),
        .halt          (halt),
        .m_axil_araddr (m_axil_araddr),
        .m_axil_arprot (m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid),
        .m_axil_arready(m_axil_arready),
        .m_axil_rdata  (m_axil_rdata),
        .m_axil_rresp  (m_axil_rresp),
        .m_axil_rvalid (m_axil_rvalid),
        .m_axil_rready (m_axil_rready),
        .sig_tdata     (sig_tdata),
        .sig_tvalid    (sig_tvalid),
        .sig_tready    (sig_tready),
        .sig_tlast     (sig_tlast),
        .busy          (busy),
        .done          (done),
        .timed_out     (timed_out),
        .resp_err      (resp_err),
        .cycle_count   (cycle_count)
    );

    // Zero-wait read slave, one response per accepted address.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_axil_rvalid <= 1'b0;
            m_axil_rdata  <= 32'h0;
            m_axil_rresp  <= 2'b00;
        end else begin
            if (m_axil_rvalid && m_axil_rready) m_axil_rvalid <= 1'b0;
            if (m_axil_arvalid && m_axil_arready) begin
                m_axil_rvalid <= 1'b1;
                m_axil_rdata  <= {16'hC0DE, m_axil_araddr[15:0]};
                m_axil_rresp  <= (m_axil_araddr == err_addr) ? 2'b10 : 2'b00;
            end
        end
    end

    always @(posedge clk) begin
        if (rstn) begin
            if (m_axil_arvalid && m_axil_arready) ar_q.push_back(m_axil_araddr);
            if (sig_tvalid && sig_tready) begin
                bd_q.push_back(sig_tdata);
                bl_q.push_back(sig_tlast);
            end
        end
    end

    task automatic start_run(input logic [31:0] b, input logic [31:0] e, input logic [31:0] to,
                             input int halt_after);
        @(negedge clk);
        ar_q.delete();
        bd_q.delete();
        bl_q.delete();
        cfg_sig_begin = b;
        cfg_sig_end   = e;
        cfg_timeout   = to;
        halt          = 1'b0;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (halt_after >= 0) begin
            repeat (halt_after) @(negedge clk);
            halt = 1'b1;
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, m_axil_arvalid, m_axil_rready, sig_tvalid, sig_tlast, timed_out,
             resp_err} !== 8'h00) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00000000", {busy, done, m_axil_arvalid,
                     m_axil_rready, sig_tvalid, sig_tlast, timed_out, resp_err});
        end
        checks++;
        if ({sig_tdata, m_axil_araddr, cycle_count, m_axil_arprot} !== 99'h0) begin
            failures++;
            $display("FAIL reset_data tdata=%h araddr=%h cnt=%0d prot=%b want all 0",
                     sig_tdata, m_axil_araddr, cycle_count, m_axil_arprot);
        end
    endtask

    task automatic test_halt_window();
        logic [31:0] exp_a[4];
        logic        exp_l[4];
        logic [31:0] got;
        bit          ok;
        exp_a = '{32'h100, 32'h104, 32'h108, 32'h10C};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        start_run(32'h100, 32'h110, 32'd0, 20);
        wait_done(500, ok);
        checks++;
        if (ok !== 1'b1) begin failures++; $display("FAIL halt_done got=%0d want=1", ok); end
        checks++;
        if (ar_q.size() != 4 || bd_q.size() != 4) begin
            failures++;
            $display("FAIL halt_counts ar=%0d beats=%0d want 4/4", ar_q.size(), bd_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < ar_q.size()) ? ar_q[i] : 32'hFFFF_FFFF;
            checks++;
            if (got !== exp_a[i]) begin
                failures++;
                $display("FAIL halt_araddr[%0d] got=%h want=%h", i, got, exp_a[i]);
            end
            got = (i < bd_q.size()) ? bd_q[i] : 32'hFFFF_FFFF;
            checks++;
            if (got !== {16'hC0DE, exp_a[i][15:0]}) begin
                failures++;
                $display("FAIL halt_tdata[%0d] got=%h want=%h", i, got, {16'hC0DE, exp_a[i][15:0]});
            end
            checks++;
            if (i < bl_q.size() && bl_q[i] !== exp_l[i]) begin
                failures++;
                $display("FAIL halt_tlast[%0d] got=%b want=%b", i, bl_q[i], exp_l[i]);
            end
        end
        checks++;
        if (cycle_count !== 32'd20 || timed_out !== 1'b0 || busy !== 1'b0 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL halt_status cnt=%0d to=%b busy=%b err=%b want 20/0/0/0",
                     cycle_count, timed_out, busy, resp_err);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        start_run(32'h300, 32'h308, 32'd50, -1);
        wait_done(500, ok);
        checks++;
        if (ok !== 1'b1) begin failures++; $display("FAIL timeout_done got=%0d want=1", ok); end
        checks++;
        if (timed_out !== 1'b1 || cycle_count !== 32'd50) begin
            failures++;
            $display("FAIL timeout_status to=%b cnt=%0d want 1/50", timed_out, cycle_count);
        end
        checks++;
        if (bd_q.size() != 2 || bd_q[0] !== 32'hC0DE0300 || bd_q[1] !== 32'hC0DE0304 ||
            bl_q[1] !== 1'b1) begin
            failures++;
            $display("FAIL timeout_beats n=%0d want 2 beats C0DE0300,C0DE0304 last=1", bd_q.size());
        end
    endtask

    task automatic test_empty_window();
        bit ok;
        start_run(32'h200, 32'h200, 32'd0, 5);
        wait_done(100, ok);
        checks++;
        if (ok !== 1'b1) begin failures++; $display("FAIL empty_done got=%0d want=1", ok); end
        checks++;
        if (ar_q.size() != 0 || bd_q.size() != 0) begin
            failures++;
            $display("FAIL empty_traffic ar=%0d beats=%0d want 0/0", ar_q.size(), bd_q.size());
        end
        checks++;
        if (cycle_count !== 32'd5 || timed_out !== 1'b0) begin
            failures++;
            $display("FAIL empty_status cnt=%0d to=%b want 5/0", cycle_count, timed_out);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit stable;
        start_run(32'h700, 32'h70C, 32'd0, 4);
        for (int i = 0; i < 200; i++) begin
            if (bd_q.size() == 1) break;
            @(negedge clk);
        end
        sig_tready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (sig_tvalid === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (ok !== 1'b1 || bd_q.size() != 1) begin
            failures++;
            $display("FAIL stall_beat2_seen got=%0d beats=%0d want 1/1", ok, bd_q.size());
        end
        // A start pulse while busy must be ignored.
        stable        = 1'b1;
        cfg_sig_begin = 32'h900;
        start         = 1'b1;
        repeat (10) begin
            if (sig_tvalid !== 1'b1 || sig_tdata !== 32'hC0DE0704 || sig_tlast !== 1'b0 ||
                m_axil_arvalid !== 1'b0) stable = 1'b0;
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            failures++;
            $display("FAIL stall_stable got=%0d want=1 (tdata=%h tlast=%b arvalid=%b)",
                     stable, sig_tdata, sig_tlast, m_axil_arvalid);
        end
        sig_tready = 1'b1;
        wait_done(200, ok);
        checks++;
        if (ok !== 1'b1 || ar_q.size() != 3 || bd_q.size() != 3) begin
            failures++;
            $display("FAIL stall_finish done=%0d ar=%0d beats=%0d want 1/3/3",
                     ok, ar_q.size(), bd_q.size());
        end
        checks++;
        if (bd_q.size() == 3 && (bd_q[2] !== 32'hC0DE0708 || bl_q[2] !== 1'b1 ||
            bl_q[1] !== 1'b0 || ar_q[2] !== 32'h708)) begin
            failures++;
            $display("FAIL stall_last tdata=%h tlast=%b araddr=%h want C0DE0708/1/708",
                     bd_q[2], bl_q[2], ar_q[2]);
        end
    endtask

    task automatic test_resp_err();
        bit ok;
        err_addr = 32'h408;
        // Unaligned begin/end are truncated to word boundaries.
        start_run(32'h403, 32'h413, 32'd0, 3);
        wait_done(300, ok);
        err_addr = 32'hFFFF_FFFF;
        checks++;
        if (ok !== 1'b1 || resp_err !== 1'b1) begin
            failures++;
            $display("FAIL resp_err done=%0d err=%b want 1/1", ok, resp_err);
        end
        checks++;
        if (bd_q.size() != 4 || bd_q[0] !== 32'hC0DE0400 || bd_q[2] !== 32'hC0DE0408 ||
            bd_q[3] !== 32'hC0DE040C || bl_q[3] !== 1'b1) begin
            failures++;
            $display("FAIL resp_beats n=%0d want 4 beats C0DE0400..C0DE040C", bd_q.size());
        end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        start_run(32'h500, 32'h510, 32'd0, 2);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (m_axil_rready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (ok !== 1'b1) begin failures++; $display("FAIL rst_reach_r got=%0d want=1", ok); end
        rstn = 1'b0;
        #1;
        checks++;
        if ({busy, done, m_axil_arvalid, m_axil_rready, sig_tvalid, sig_tlast, timed_out,
             resp_err} !== 8'h00 || sig_tdata !== 32'h0 || cycle_count !== 32'h0 ||
            m_axil_araddr !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_outputs busy=%b rready=%b tdata=%h cnt=%0d araddr=%h want 0",
                     busy, m_axil_rready, sig_tdata, cycle_count, m_axil_araddr);
        end
        @(negedge clk);
        rstn = 1'b1;
        start_run(32'h600, 32'h608, 32'd0, 3);
        wait_done(200, ok);
        checks++;
        if (ok !== 1'b1 || bd_q.size() != 2 || bd_q[0] !== 32'hC0DE0600 ||
            bd_q[1] !== 32'hC0DE0604 || cycle_count !== 32'd3) begin
            failures++;
            $display("FAIL rst_rerun done=%0d beats=%0d cnt=%0d want 1/2/3",
                     ok, bd_q.size(), cycle_count);
        end
    endtask

    initial begin
        rstn           = 1'b0;
        start          = 1'b0;
        cfg_sig_begin  = 32'h0;
        cfg_sig_end    = 32'h0;
        cfg_timeout    = 32'h0;
        halt           = 1'b0;
        m_axil_arready = 1'b1;
        sig_tready     = 1'b1;
        err_addr       = 32'hFFFF_FFFF;
        test_reset();
        test_halt_window();
        test_timeout();
        test_empty_window();
        test_backpressure();
        test_resp_err();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
